// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, bit-order tags and baud divisor helpers.
package uart_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_ERR    = 3'd5;

   localparam logic [23:0] FIRST_LSB = "lsb";
   localparam logic [23:0] FIRST_MSB = "msb";

   function automatic int unsigned calc_fullbaud(input int unsigned clk_freq,
                                                 input int unsigned baudrate);
      return clk_freq / baudrate;
   endfunction

   function automatic int unsigned calc_halfbaud(input int unsigned clk_freq,
                                                 input int unsigned baudrate);
      return calc_fullbaud(clk_freq, baudrate) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-stage synchroniser for an asynchronous input; every stage resets to 1 (idle line level).
module uart_rx_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, mid-bit sampling, stop check, one-cycle valid/error strobes.
// Define UART_RX_PARITY_EN to expect an even-parity bit and expose parity_err.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned STOP_BITS = 1,
   parameter logic [23:0] FIRST_BIT = FIRST_LSB,
   parameter int unsigned BAUDRATE  = 115200,
   parameter int unsigned CLK_FREQ  = 75_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 parity_err
`endif
);

   localparam int unsigned FULLBAUD = calc_fullbaud(CLK_FREQ, BAUDRATE);
   localparam int unsigned HALFBAUD = calc_halfbaud(CLK_FREQ, BAUDRATE);
   localparam int unsigned CNT_W    = $clog2(FULLBAUD + 1);

   logic                 rx_s;
   logic [2:0]           state_q, state_d;
   logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d, shift_in;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 half_hit, full_hit;
`ifdef UART_RX_PARITY_EN
   logic                 pbad_q, pbad_d;
   logic                 perr_q, perr_d;
`endif

   uart_rx_sync #(.STAGES(2)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (rx),
      .q_o   (rx_s)
   );

   generate
      if (FIRST_BIT == FIRST_MSB) begin : g_msb
         assign shift_in = {shift_q[DATA_BITS-2:0], rx_s};
      end else begin : g_lsb
         assign shift_in = {rx_s, shift_q[DATA_BITS-1:1]};
      end
   endgenerate

   assign half_hit = (clk_cnt_q == CNT_W'(HALFBAUD - 1));
   assign full_hit = (clk_cnt_q == CNT_W'(FULLBAUD - 1));

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q + CNT_W'(1);
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_d    = pbad_q;
      perr_d    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            clk_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            pbad_d    = 1'b0;
`endif
            if (!rx_s) state_d = ST_START;
         end
         ST_START: begin
            if (half_hit) begin
               clk_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (full_hit) begin
               clk_cnt_d = '0;
               shift_d   = shift_in;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                  bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d   = ST_PARITY;
`else
                  state_d   = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (full_hit) begin
               clk_cnt_d = '0;
               pbad_d    = (^shift_q) ^ rx_s;
               state_d   = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (full_hit) begin
               clk_cnt_d = '0;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (!rx_s) begin
                  // Framing error wins over parity; ERR waits out a held break.
                  ferr_d  = 1'b1;
                  state_d = ST_ERR;
               end else if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                  state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                  if (pbad_q) begin
                     perr_d = 1'b1;
                  end else begin
                     valid_d = 1'b1;
                     data_d  = shift_q;
                  end
`else
                  valid_d = 1'b1;
                  data_d  = shift_q;
`endif
               end
            end
         end
         ST_ERR: begin
            clk_cnt_d = '0;
            if (rx_s) state_d = ST_IDLE;
         end
         default: begin
            clk_cnt_d = '0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pbad_q    <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
         pbad_q    <= pbad_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver; the receive-side counterpart of uart_tx on the same UART link.
- Synchronises the incoming line, detects a start bit and samples each data bit at mid-bit.
- Checks the stop bit(s), then presents the received word with a one-cycle valid strobe.
- Sits between the board RX pin and the command/decoder logic, in the same clock domain as uart_tx.

Parameters:
- DATA_BITS, 8: data bits per frame (5..9).
- STOP_BITS, 1: stop bits checked per frame (1 or 2).
- FIRST_BIT, "lsb": bit order on the line; "lsb" or "msb".
- BAUDRATE, 115200: line rate in bit/s.
- CLK_FREQ, 75_000_000: clk frequency in Hz. FULLBAUD = CLK_FREQ/BAUDRATE (integer divide, must be ≥ 4). HALFBAUD = FULLBAUD/2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  DATA_BITS  last correctly framed word; rx_data[0] is the first bit on the line when FIRST_BIT="lsb".
- rx_valid  output  1  one-cycle pulse: rx_data updated.
- frame_err  output  1  one-cycle pulse: a stop bit was sampled low.

Behaviour:
- Reset (rst_n low, async): rx_data=0, rx_valid=0, frame_err=0, synchroniser flops=1, counters=0, state=IDLE. Deasserting reset mid-frame restarts cleanly in IDLE; the partial frame is discarded.
- Synchroniser: 2-FF chain on rx, both flops reset to 1. All decisions use the second flop (rx_s), adding 2 cycles of input delay.
- Counters: clk_cnt counts 0..FULLBAUD-1; bit_cnt counts bits within DATA/STOP.
- IDLE:
  - rx_s==0 → START, clk_cnt=0.
- START:
  - When clk_cnt==HALFBAUD-1, sample rx_s.
  - rx_s==1 → false start (glitch): return to IDLE, no output.
  - rx_s==0 → DATA, clk_cnt=0, bit_cnt=0.
- DATA:
  - Every clk_cnt==FULLBAUD-1, sample rx_s into the shift register and increment bit_cnt.
  - After DATA_BITS samples → STOP.
  - "lsb": shift right, first sample ends in bit 0. "msb": first sample ends in bit DATA_BITS-1.
- STOP:
  - Sample each stop bit at FULLBAUD spacing.
  - Any stop sample low → flag error, then go to ERR.
  - After STOP_BITS samples all high → update rx_data and go to IDLE.
  - rx_valid (or frame_err) asserts on the clock edge after the final stop sample, for exactly 1 cycle.
- ERR:
  - Wait until rx_s==1, then go to IDLE. A held break raises a single frame_err, not repeated errors.
- Outputs:
  - rx_data holds its value until the next good frame; it is never changed on a framing error.
  - rx_valid and frame_err are never high in the same cycle.
  - No backpressure: a consumer that misses the pulse loses the word.
- Latency: line start edge → rx_valid ≈ 2 + HALFBAUD + (DATA_BITS+STOP_BITS)·FULLBAUD + 1 cycles.
- Back-to-back frames: receiving from IDLE immediately after the stop sample allows a new start bit half a bit period later; zero-idle-gap frames are received without loss.
- Undefined state encodings → IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - One even-parity bit is expected between the data and stop bits, and a PARITY state samples it.
  - Mismatch → extra output parity_err (1 bit, 1-cycle pulse, reset 0). rx_valid is suppressed and rx_data is unchanged.
  - Stop-bit checking still applies. If both fail, frame_err takes priority and parity_err stays low.
- Undefined: no PARITY state, no parity_err port; frame format is start+data+stop.

Decomposition:
- Package uart_pkg:
  - State encodings IDLE/START/DATA/PARITY/STOP/ERR.
  - Functions computing FULLBAUD and HALFBAUD from CLK_FREQ/BAUDRATE.
  - The bit-order string constants "lsb"/"msb".
  - uart_tx should migrate to the same package.
- Sub-module: uart_rx_sync, a parameterised N-stage (default 2) synchroniser with reset value 1, reusable for other async inputs.

Test Plan (CLK_FREQ=1_152_000, BAUDRATE=115200 → FULLBAUD=10, HALFBAUD=5):
- Frame 0xA5, lsb-first, 1 stop → one rx_valid pulse, rx_data=0xA5, frame_err never high.
- 3-cycle low glitch on idle rx → FSM returns to IDLE, no rx_valid, no frame_err.
- Frame 0x3C with stop bit driven low, then line high → single frame_err pulse; rx_data keeps its prior value; the next good frame 0x5A yields rx_valid with 0x5A.
- Back-to-back 0x00, 0xFF, 0x81 with zero idle gap → three rx_valid pulses in order with the correct data.
- FIRST_BIT="msb", line bits 1,0,0,0,0,0,0,0 → rx_data=0x80. Loopback via uart_tx (same parameters) with random 200 bytes → all match.
- rst_n pulsed low mid-DATA, then frame 0x42 → no output for the aborted frame; 0x42 received correctly. With UART_RX_PARITY_EN, a wrong parity bit on 0x42 → parity_err pulse, no rx_valid.
